// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and the data memory responder.
// The master side issues requests and the slave side answers with a one-cycle strobe.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: accepts one request, waits LAT cycles,
// then emits a single response strobe; stores and error counting commit on the edge leaving RESP.
module dmem_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH];

    logic        bad;
    logic [AW-1:0] idx;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0)
            return 32'hA00000AA;
        else if (i < 10)
            return 32'(i) * 32'h10000011;
        else
            return 32'h0;
    endfunction

    // Anything above the word array, or not word aligned, is rejected.
    assign bad = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign idx = addr_q[AW+1:2];

    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            err_count     <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= init_word(i);
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt     <= 3'(LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= bad;
                        bus.rsp_rdata <= (!we_q && !bad) ? mem[idx] : 32'h0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= '0;
                    if (bad) begin
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end else if (we_q) begin
                        mem[idx] <= wdata_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LAT, default 2, sets the wait cycles between request acceptance and response; the legal range is 1..7.
REQ-002 Parameter DEPTH, default 32, sets the number of 32-bit data words; the word index is addr[6:2].
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  the pipeline MEM stage presents a load/store request.
REQ-006 req_ready  output  1  the block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  one-cycle response strobe.
REQ-011 rsp_rdata  output  32  load data, valid only while rsp_valid is high.
REQ-012 rsp_err  output  1  the request was misaligned or out of range; valid only while rsp_valid is high.
REQ-013 busy  output  1  stall request to the pipeline; high whenever a request is in flight.
REQ-014 err_count  output  8  saturating count of error responses.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 Acceptance SHALL occur on a rising edge where req_valid=1 and req_ready=1.
REQ-019 On acceptance, req_we, req_addr and req_wdata SHALL be latched, the state SHALL become WAIT, and the counter SHALL be loaded with LAT-1.
REQ-020 In WAIT, the block SHALL decrement the counter each edge; on the edge where the counter is 0, the state SHALL become RESP.
REQ-021 In RESP, rsp_valid SHALL be 1 for exactly one cycle, and the next edge SHALL return the state to IDLE.
REQ-022 For a request accepted at edge k, rsp_valid SHALL be high in the cycle following edge k+LAT.
REQ-023 No response back-pressure exists; the consumer SHALL sample the response in the rsp_valid cycle.
REQ-024 An error SHALL be flagged when latched addr[1:0] != 0 (misaligned) or latched addr[31:7] != 0 (out of range for DEPTH=32).
REQ-025 A good load SHALL drive rsp_rdata with mem[addr[6:2]] in the RESP cycle.
REQ-026 Stores and errored requests SHALL drive rsp_rdata to 0.
REQ-027 A good store SHALL write mem[addr[6:2]] <= wdata on the edge leaving RESP, so the write is visible to any later-accepted request.
REQ-028 An errored request SHALL NOT modify memory.
REQ-029 rsp_err SHALL be 1 in RESP for errored requests and 0 otherwise.
REQ-030 err_count SHALL increment on the edge leaving RESP for an errored request and SHALL saturate at 255 without wrapping.
REQ-031 req_valid asserted while the block is not in IDLE SHALL be ignored: no latching and no side effects.
REQ-032 A request held high continuously SHALL be accepted again on the first edge in IDLE, giving a throughput of one request per LAT+2 cycles.
REQ-033 Outside the RESP cycle, rsp_valid SHALL be 0, rsp_rdata SHALL be 0 and rsp_err SHALL be 0.

Reset
REQ-034 While rst=1, the block SHALL force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, err_count=0 and req_ready=1, independent of clk.
REQ-035 Reset SHALL load mem[0..9] = A00000AA, 10000011, 20000022, 30000033, 40000044, 50000055, 60000066, 70000077, 80000088, 90000099, and mem[10..31] = 0.
REQ-036 Reset asserted mid-operation (WAIT or RESP) SHALL abort the request: no memory write, no response, and no err_count change.
REQ-037 The first acceptance after reset SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-038 Scenario (load): reset, then load 0x04 accepted at edge k -> rsp_valid high only in the cycle after edge k+2, rsp_rdata=10000011, rsp_err=0.
REQ-039 Scenario (store then load): store 0x28 with DEADBEEF -> response rdata=0, err=0; then load 0x28 -> DEADBEEF.
REQ-040 Scenario (errors): load 0x06 -> rsp_err=1, rdata=0, err_count=1; store 0x80 with 12345678 -> rsp_err=1, err_count=2; then load 0x00 -> A00000AA, confirming no aliasing.
REQ-041 Scenario (held request): req_valid held high for 12 cycles with LAT=2 -> accepted every 4 cycles, busy high 3 of every 4 cycles, req_ready high only in IDLE.
REQ-042 Scenario (reset mid-write): store 0x00 with FFFFFFFF, rst pulsed during WAIT -> no rsp_valid; a load of 0x00 after release returns A00000AA.
REQ-043 Scenario (saturation): 300 misaligned requests -> err_count reads 255 and stays at 255.
